// File: rtl/dsp_sys_arr_pkg.sv
// rtl/dsp_sys_arr_pkg.sv - shared types for the systolic-array datapath and its FIFO readers
//
// Contents:
//   WORD_W          width of one array data word
//   word_t          one array data word, as carried by the FIFOs and edge feeders
//   reader_state_t  fifo_stream_reader FSM states (IDLE, STREAM, DRAIN)
package dsp_sys_arr_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } reader_state_t;

endpackage

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - pops an N-word burst from a FWFT FIFO onto a registered valid/ready stream
//
// Ports:
//   CLK, RST    clock and synchronous active-high reset
//   start, len  one-cycle burst request and its length in words (sampled in IDLE only)
//   busy        burst in progress, from the cycle after an accepted start until done
//   done        one-cycle completion pulse (also issued for a zero-length request)
//   fifo_empty  FIFO is_empty
//   fifo_dat    FIFO dat_out, head word while non-empty
//   fifo_pop    FIFO pop, combinational
//   out_valid, out_data, out_last, out_ready
//               downstream stream; out_last marks the final word of the burst
module fifo_stream_reader
    import dsp_sys_arr_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    input  word_t            fifo_dat,
    output logic             fifo_pop,
    output logic             out_valid,
    output word_t            out_data,
    output logic             out_last,
    input  logic             out_ready
);

    reader_state_t    state;
    logic [LEN_W-1:0] remaining;

    // Pop only when the output register is free or being drained this cycle.
    // The remaining!=0 term keeps the counter from ever wrapping, and RST keeps
    // the FIFO untouched while a burst is being abandoned.
    assign fifo_pop = !RST
                   && (state == STREAM)
                   && !fifo_empty
                   && (remaining != '0)
                   && (!out_valid || out_ready);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            remaining <= len;
                            busy      <= 1'b1;
                            state     <= STREAM;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (fifo_pop) begin
                        // Reloading here also covers a handshake in the same cycle,
                        // so out_valid stays high without a bubble.
                        out_data  <= fifo_dat;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == LEN_W'(1));
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    // The last word is already in the output register; wait for it to leave.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader with a 16-deep FWFT FIFO model
module tb_fifo_stream_reader;
    import dsp_sys_arr_pkg::*;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             fifo_empty;
    word_t            fifo_dat;
    logic             fifo_pop;
    logic             out_valid;
    word_t            out_data;
    logic             out_last;
    logic             out_ready;

    // FIFO model (SIZE=16, first-word-fall-through)
    logic             push;
    word_t            push_data;
    logic             flush;
    word_t            mem [16];
    logic [3:0]       rd_ptr = '0;
    logic [3:0]       wr_ptr = '0;
    logic [4:0]       ocp = '0;
    int               pops_total = 0;

    // Observation
    word_t            rcv_data [$];
    logic             rcv_last [$];
    int               done_count = 0;

    int               checks = 0;
    int               failures = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.LEN_W(LEN_W)) dut (
        .CLK        (clk),
        .RST        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_dat   (fifo_dat),
        .fifo_pop   (fifo_pop),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready)
    );

    assign fifo_empty = (ocp == 5'd0);
    assign fifo_dat   = mem[rd_ptr];

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            ocp    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 4'd1;
            end
            if (fifo_pop) begin
                rd_ptr     <= rd_ptr + 4'd1;
                pops_total <= pops_total + 1;
            end
            ocp <= ocp + {4'd0, push} - {4'd0, fifo_pop};
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rcv_data.push_back(out_data);
            rcv_last.push_back(out_last);
        end
        if (done) begin
            done_count <= done_count + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            push      = 1'b1;
            push_data = word_t'(first + i);
            tick();
        end
        push = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic clear_rcv();
        rcv_data.delete();
        rcv_last.delete();
    endtask

    initial begin
        int pops0;
        int dc0;
        int n;

        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        out_ready = 1'b0;
        push      = 1'b0;
        push_data = '0;
        flush     = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_fifo_pop",  32'(fifo_pop),  32'd0);
        check("rst_ocp",       32'(ocp),       32'd0);
        rst = 1'b0;
        tick();

        // Basic burst of 4, no stalls
        clear_rcv();
        push_words(1, 4);
        check("b4_ocp_pre", 32'(ocp), 32'd4);
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 16'd4;
        tick();
        start = 1'b0;
        check("b4_pop_c1",   32'(fifo_pop),  32'd1);
        check("b4_busy_c1",  32'(busy),      32'd1);
        check("b4_valid_c1", 32'(out_valid), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("b4_pop_w%0d", i),   32'(fifo_pop),  32'd1);
            check($sformatf("b4_valid_w%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("b4_data_w%0d", i),  32'(out_data),  32'(i));
            check($sformatf("b4_last_w%0d", i),  32'(out_last),  32'd0);
        end
        tick();
        check("b4_pop_w4",  32'(fifo_pop), 32'd0);
        check("b4_data_w4", 32'(out_data), 32'd4);
        check("b4_last_w4", 32'(out_last), 32'd1);
        check("b4_done_w4", 32'(done),     32'd0);
        tick();
        check("b4_done",      32'(done),      32'd1);
        check("b4_busy_done", 32'(busy),      32'd0);
        check("b4_valid_end", 32'(out_valid), 32'd0);
        check("b4_ocp_end",   32'(ocp),       32'd0);
        tick();
        check("b4_done_pulse", 32'(done), 32'd0);

        // Backpressure: stall 3 cycles while word 2 is presented
        clear_rcv();
        push_words(1, 6);
        start = 1'b1;
        len   = 16'd6;
        tick();
        start = 1'b0;
        tick();
        check("bp_data1", 32'(out_data), 32'd1);
        tick();
        out_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_hold_data_%0d", k),  32'(out_data),  32'd2);
            check($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold_pop_%0d", k),   32'(fifo_pop),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        wait_done("bp_done", 20);
        check("bp_count", 32'(rcv_data.size()), 32'd6);
        for (int i = 0; i < 6 && i < rcv_data.size(); i++) begin
            check($sformatf("bp_word%0d", i), 32'(rcv_data[i]), 32'(i + 1));
            check($sformatf("bp_last%0d", i), 32'(rcv_last[i]), (i == 5) ? 32'd1 : 32'd0);
        end
        check("bp_ocp_end", 32'(ocp), 32'd0);
        tick();

        // Underflow stall: burst of 3 started on an empty FIFO
        clear_rcv();
        start = 1'b1;
        len   = 16'd3;
        tick();
        start = 1'b0;
        tick();
        check("uf_busy_empty", 32'(busy),     32'd1);
        check("uf_pop_empty",  32'(fifo_pop), 32'd0);
        push_words(7, 1);
        push_words(8, 1);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("uf_stall_busy_%0d", k), 32'(busy),     32'd1);
            check($sformatf("uf_stall_pop_%0d", k),  32'(fifo_pop), 32'd0);
            tick();
        end
        check("uf_count_mid", 32'(rcv_data.size()), 32'd2);
        if (rcv_data.size() >= 2) begin
            check("uf_word7", 32'(rcv_data[0]), 32'd7);
            check("uf_word8", 32'(rcv_data[1]), 32'd8);
        end
        push_words(9, 1);
        wait_done("uf_done", 10);
        check("uf_count", 32'(rcv_data.size()), 32'd3);
        if (rcv_data.size() >= 3) begin
            check("uf_word9", 32'(rcv_data[2]), 32'd9);
            check("uf_last9", 32'(rcv_last[2]), 32'd1);
            check("uf_last7", 32'(rcv_last[0]), 32'd0);
        end
        tick();

        // Short burst leaves extra words; zero-length start in the done cycle
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_rcv();
        push_words(1, 5);
        start = 1'b1;
        len   = 16'd3;
        tick();
        start = 1'b0;
        wait_done("sh_done", 20);
        start = 1'b1;
        len   = 16'd0;
        pops0 = pops_total;
        tick();
        start = 1'b0;
        check("z_done", 32'(done),        32'd1);
        check("z_pop",  32'(fifo_pop),    32'd0);
        check("z_busy", 32'(busy),        32'd0);
        check("z_pops", 32'(pops_total),  32'(pops0));
        check("sh_count", 32'(rcv_data.size()), 32'd3);
        for (int i = 0; i < 3 && i < rcv_data.size(); i++) begin
            check($sformatf("sh_word%0d", i), 32'(rcv_data[i]), 32'(i + 1));
        end
        check("sh_ocp", 32'(ocp), 32'd2);
        tick();
        check("z_done_pulse", 32'(done), 32'd0);

        // Reset in the middle of a burst of 5
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_rcv();
        push_words(1, 5);
        pops0 = pops_total;
        dc0   = done_count;
        start = 1'b1;
        len   = 16'd5;
        tick();
        start = 1'b0;
        n = 0;
        while (rcv_data.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check("mr_handshakes", 32'(rcv_data.size()), 32'd2);
        rst = 1'b1;
        #1;
        check("mr_pop_in_rst", 32'(fifo_pop), 32'd0);
        tick();
        check("mr_busy",      32'(busy),      32'd0);
        check("mr_done",      32'(done),      32'd0);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_data",  32'(out_data),  32'd0);
        check("mr_out_last",  32'(out_last),  32'd0);
        check("mr_pops",      32'(pops_total - pops0), 32'd3);
        check("mr_ocp",       32'(ocp),       32'(5 - (pops_total - pops0)));
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("mr_no_done",   32'(done_count), 32'(dc0));
        check("mr_busy_after", 32'(busy),      32'd0);
        check("mr_pop_after", 32'(fifo_pop),   32'd0);
        check("mr_ocp_after", 32'(ocp),        32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the systolic-array input FIFOs. It accepts a burst command of N words, pops them from a first-word-fall-through FIFO, and presents them downstream on a registered valid/ready stream with a last-word marker. It sits between each `fifo` instance's read port and the array edge feeder, and is the consumer counterpart to the FIFO's push side.

## Interface
Parameters:
- `LEN_W`, 16, width of the burst-length command; maximum burst is 2^LEN_W − 1 words.

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `start`  in  1  one-cycle burst request; sampled only in IDLE.
- `len`  in  LEN_W  burst length in words, sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until the cycle `done` is high.
- `done`  out  1  one-cycle pulse when a burst completes.
- `fifo_empty`  in  1  connects to FIFO `is_empty`.
- `fifo_dat`  in  word_t  connects to FIFO `dat_out`, which shows the head word while non-empty.
- `fifo_pop`  out  1  connects to FIFO `pop`; combinational.
- `out_valid`  out  1  downstream data valid.
- `out_data`  out  word_t  downstream data.
- `out_last`  out  1  qualifies the final word of the burst.
- `out_ready`  in  1  downstream accept.

## Operation
- FSM states are `IDLE`, `STREAM` and `DRAIN`.
- `IDLE`:
  - `start` with `len`≠0: load `remaining`←`len` and go to `STREAM`.
  - `start` with `len`=0: pulse `done` on the next cycle and stay in `IDLE`.
- `STREAM`:
  - `fifo_pop` = `!fifo_empty && remaining≠0 && (!out_valid || out_ready)`.
  - On a pop:
    - `out_data`←`fifo_dat`, `out_valid`←1, `remaining`←`remaining`−1.
    - `out_last`←(`remaining`==1).
  - A pop with `remaining`==1 moves the FSM to `DRAIN`.
  - Handshake with no pop: `out_valid`←0.
- `DRAIN`:
  - `fifo_pop`=0.
  - On `out_valid && out_ready`: clear `out_valid` and `out_last`, pulse `done`, go to `IDLE`.
- `start` is ignored while `busy`.
- FIFO empty mid-burst: the block stalls with no pop and no error, and resumes when the FIFO has data.
- Stream rules: `out_data` and `out_last` hold stable while `out_valid && !out_ready`. No word is ever dropped or duplicated.
- The counter is LEN_W bits, decrement only, and never wraps; the pop gate guarantees `remaining`≥1 at each decrement.
- The block never pops past `len`. Words beyond the burst stay in the FIFO.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `fifo_pop`=0, `remaining`=0, state=`IDLE`.
- Reset mid-burst abandons the burst:
  - A word held in the output register is discarded.
  - FIFO contents not yet popped are untouched.
  - No `done` pulse is issued.
- `start` at edge t → first possible `fifo_pop` in cycle t+1.
- `fifo_pop` in cycle k → `out_valid` with that word in cycle k+1.
- Throughput is one word per cycle while the FIFO is non-empty and `out_ready`=1.
- Final handshake in cycle k → `done`=1 and `busy`=0 in cycle k+1.
- A new `start` is accepted in that same cycle k+1.
- Burst of N with no stalls: `done` arrives N+2 cycles after `start`.
- Simultaneous handshake and pop: the output register reloads in the same edge, and `out_valid` stays high.

## Structure
- `word_t` comes from `dsp_sys_arr_pkg`.
- Add `reader_state_t` (enum IDLE/STREAM/DRAIN) to `dsp_sys_arr_pkg`.
- Single module `fifo_stream_reader`, with no sub-module.
- At the top level it connects to the reader-side signals of `FIFO_if` (`pop`, `dat_out`, `is_empty`).

## Test plan
Bench: `fifo` with SIZE=16 plus this block; data words 1, 2, 3, ….
- Reset: hold `RST` 2 cycles → all outputs 0, `busy`=0; FIFO `ocp` unchanged.
- FIFO holds 1..4, `start` with `len`=4, `out_ready`=1 →
  - `fifo_pop` high 4 consecutive cycles.
  - `out_data` = 1, 2, 3, 4 on consecutive cycles starting one cycle later; `out_last` only with 4.
  - `done` one cycle after 4 is accepted; FIFO empty.
- Backpressure: FIFO holds 1..6, `len`=6, `out_ready` low for 3 cycles while `out_data`=2 →
  - `out_data` holds 2 and `fifo_pop`=0 during the stall.
  - Stream completes 1..6 in order; `ocp` ends at 0.
- Underflow stall: `len`=3 with FIFO empty, push 7 and 8, then 9 five cycles later →
  - Words 7 and 8 delivered.
  - `busy` stays high with no pop until 9 arrives.
  - 9 delivered with `out_last`, then `done`.
- Short and extra: FIFO holds 1..5, `len`=3 → 1, 2, 3 delivered and `ocp`=2 afterwards. A following `start` with `len`=0 → `done` next cycle, no pop.
- Reset mid-burst: FIFO holds 1..5, `len`=5, assert `RST` after 2 handshakes →
  - Outputs zero, `busy`=0, no `done`.
  - FIFO `ocp`=2 or 3 depending on whether word 3 was popped; that count is checked exactly against the pop count.
